// File: rtl/clk_period_meter.sv
// clk_period_meter
// ----------------
// Health monitor for a slow clock or periodic signal. It measures the
// signal against the 27 MHz system clock. Each full period between two
// detected rising edges of clk_in_i produces:
//   - the period length,
//   - the number of cycles the signal was high within that period,
//   - a tolerance flag against the nominal period.
// A loss-of-clock flag rises when no edge arrives within TIMEOUT cycles.
//
// Ports:
//   clk27m_i        system clock, 27 MHz
//   rst_i           synchronous reset, active-high
//   clk_in_i        measured signal, asynchronous to clk27m_i
//   period_o        last measured period, in clk27m_i cycles
//   high_time_o     clk27m_i cycles clk_in_i was high within that period
//   period_valid_o  one-cycle pulse when period_o/high_time_o update
//   freq_ok_o       last period within EXPECTED +/- TOL and no timeout
//   timeout_o       no rising edge seen for TIMEOUT cycles
//   state_o         measurement FSM state (0 = IDLE, 1 = MEASURE)
//
// Handshake: period_valid_o is a single-cycle strobe with no back-pressure.
// While it is high, period_o, high_time_o and freq_ok_o already hold the
// new measurement; they then hold it until the next strobe.

module clk_period_meter #(
    parameter int CNT_W    = 16,
    parameter int EXPECTED = 54,
    parameter int TOL      = 1,
    parameter int TIMEOUT  = 4096
) (
    input  logic             clk27m_i,
    input  logic             rst_i,
    input  logic             clk_in_i,
    output logic [CNT_W-1:0] period_o,
    output logic [CNT_W-1:0] high_time_o,
    output logic             period_valid_o,
    output logic             freq_ok_o,
    output logic             timeout_o,
    output logic             state_o
);

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_e;

    localparam logic [CNT_W-1:0] TIMEOUT_C  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] TIMEOUT_M1 = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W:0]   EXP_C      = (CNT_W + 1)'(EXPECTED);
    localparam logic [CNT_W:0]   TOL_C      = (CNT_W + 1)'(TOL);

    // Synchronizer (sync1/sync2) plus one extra stage for edge detection.
    logic sync1_q, sync2_q, sync3_q;
    logic rise;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic             valid_q, valid_d;
    logic             freq_ok_q, freq_ok_d;
    logic             timeout_q, timeout_d;

    logic             hit_limit;
    logic [CNT_W:0]   period_next;
    logic [CNT_W:0]   period_diff;
    logic             in_tol;

    always_ff @(posedge clk27m_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= clk_in_i;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    assign rise = sync2_q & ~sync3_q;

    // cnt holds the cycles elapsed since the last rise (or reset), minus one.
    // It saturates at TIMEOUT, so the loss-of-clock threshold is crossed
    // only once per silent stretch.
    always_comb begin
        cnt_d  = cnt_q;
        hcnt_d = hcnt_q;
        if (rise) begin
            cnt_d  = '0;
            hcnt_d = '0;
        end else begin
            if (cnt_q != TIMEOUT_C) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            if (sync3_q && (hcnt_q != TIMEOUT_C)) begin
                hcnt_d = hcnt_q + CNT_W'(1);
            end
        end
    end

    assign hit_limit = (cnt_q == TIMEOUT_M1);

    // The rise cycle itself is part of the period, hence the +1. The
    // difference is taken one bit wider so it cannot wrap.
    assign period_next = {1'b0, cnt_q} + (CNT_W + 1)'(1);
    assign period_diff = (period_next >= EXP_C) ? (period_next - EXP_C)
                                                : (EXP_C - period_next);
    assign in_tol      = (period_diff <= TOL_C);

    always_comb begin
        state_d   = state_q;
        period_d  = period_q;
        high_d    = high_q;
        valid_d   = 1'b0;
        freq_ok_d = freq_ok_q;
        timeout_d = timeout_q;
        case (state_q)
            IDLE: begin
                // The first edge only arms the measurement.
                if (rise) begin
                    state_d = MEASURE;
                end else if (hit_limit) begin
                    // No edge at all since reset.
                    timeout_d = 1'b1;
                    freq_ok_d = 1'b0;
                end
            end
            MEASURE: begin
                // A rise on the threshold cycle wins over the timeout.
                if (rise) begin
                    period_d  = period_next[CNT_W-1:0];
                    // sync3 is always low on the rise cycle, so hcnt
                    // already covers every high cycle of the period.
                    high_d    = hcnt_q;
                    valid_d   = 1'b1;
                    freq_ok_d = in_tol;
                    timeout_d = 1'b0;
                end else if (hit_limit) begin
                    timeout_d = 1'b1;
                    freq_ok_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk27m_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            hcnt_q    <= '0;
            state_q   <= IDLE;
            period_q  <= '0;
            high_q    <= '0;
            valid_q   <= 1'b0;
            freq_ok_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            hcnt_q    <= hcnt_d;
            state_q   <= state_d;
            period_q  <= period_d;
            high_q    <= high_d;
            valid_q   <= valid_d;
            freq_ok_q <= freq_ok_d;
            timeout_q <= timeout_d;
        end
    end

    assign period_o       = period_q;
    assign high_time_o    = high_q;
    assign period_valid_o = valid_q;
    assign freq_ok_o      = freq_ok_q;
    assign timeout_o      = timeout_q;
    assign state_o        = (state_q == MEASURE);

endmodule

// File: tb/tb_clk_period_meter.sv
// Self-checking bench for clk_period_meter.
// The reference model works on the recorded input level of every cycle:
// a period is the edge distance between two detected rises, and the high
// time is the number of high input cycles inside that period.

module tb_clk_period_meter;

  localparam int W    = 16;
  localparam int EXP  = 54;
  localparam int TOL  = 1;
  localparam int TMO  = 200;
  localparam int LAT  = 3;
  localparam int MAXE = 100000;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst;
  logic         clk_in;
  logic [W-1:0] period;
  logic [W-1:0] high_time;
  logic         period_valid;
  logic         freq_ok;
  logic         timeout;
  logic         state;

  always #5 clk = ~clk;

  clk_period_meter #(
    .CNT_W   (W),
    .EXPECTED(EXP),
    .TOL     (TOL),
    .TIMEOUT (TMO)
  ) dut (
    .clk27m_i      (clk),
    .rst_i         (rst),
    .clk_in_i      (clk_in),
    .period_o      (period),
    .high_time_o   (high_time),
    .period_valid_o(period_valid),
    .freq_ok_o     (freq_ok),
    .timeout_o     (timeout),
    .state_o       (state)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit lvl [0:MAXE];      // input level driven during each cycle
  int n      = 0;        // posedge count
  int last_ev = 0;       // edge of last rise or reset
  bit armed  = 0;
  int m_period = 0, m_high = 0;
  bit m_valid = 0, m_fok = 0, m_tmo = 0;
  int n_valid = 0;

  initial begin
    forever begin
      @(posedge clk);
      n++;
      if (n >= MAXE) begin
        $display("FAIL model_overflow actual=%0d required=%0d", n, MAXE - 1);
        bad++;
        $fatal(1, "edge budget exceeded");
      end
      lvl[n-1] = clk_in;
      if (rst) begin
        // Reset clears the synchronizer: the last three samples read as low.
        for (int j = 1; j <= LAT; j++) if (n - j >= 0) lvl[n-j] = 1'b0;
        armed = 0; last_ev = n;
        m_period = 0; m_high = 0; m_valid = 0; m_fok = 0; m_tmo = 0;
      end else begin
        m_valid = 0;
        if (n > LAT && lvl[n-LAT] && !lvl[n-LAT-1]) begin
          if (armed) begin
            m_period = n - last_ev;
            m_high = 0;
            for (int k = last_ev - LAT; k <= n - LAT - 1; k++) m_high += lvl[k];
            m_fok = (m_period - EXP <= TOL) && (EXP - m_period <= TOL);
            m_tmo = 0;
            m_valid = 1;
            n_valid++;
          end
          armed = 1;
          last_ev = n;
        end else if (n - last_ev == TMO) begin
          m_tmo = 1; m_fok = 0; armed = 0;
        end
      end
    end
  end

  // ---------------- scoreboard: compare every cycle ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (n >= 1) begin
        check("period",       int'(period),       m_period);
        check("high_time",    int'(high_time),    m_high);
        check("period_valid", int'(period_valid), int'(m_valid));
        check("freq_ok",      int'(freq_ok),      int'(m_fok));
        check("timeout",      int'(timeout),      int'(m_tmo));
        check("state",        int'(state),        int'(armed));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_level(input bit v, input int cycles);
    clk_in = v;
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wave(input int hi, input int lo, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      set_level(1'b1, hi);
      set_level(1'b0, lo);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clk_in = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int h, l, mode;
    rst = 1'b1;
    clk_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_period",  int'(period),  0);
    check("reset_timeout", int'(timeout), 0);

    // Nominal 27/27: the first valid follows the second rise.
    set_level(1'b1, 10);
    check("first_edge_no_valid", n_valid, 0);
    set_level(1'b1, 17);
    set_level(1'b0, 27);
    wave(27, 27, 5);
    set_level(1'b1, 4);
    check("nom_period",  int'(period),    54);
    check("nom_high",    int'(high_time), 27);
    check("nom_freq_ok", int'(freq_ok),   1);
    check("nom_timeout", int'(timeout),   0);
    set_level(1'b1, 23);
    set_level(1'b0, 27);

    // Period 55 (in tolerance) then 56 (out of tolerance).
    wave(28, 27, 2);
    set_level(1'b1, 4);
    check("p55_period",  int'(period),  55);
    check("p55_freq_ok", int'(freq_ok), 1);
    set_level(1'b1, 24);
    set_level(1'b0, 28);
    wave(28, 28, 1);
    set_level(1'b1, 4);
    check("p56_period",  int'(period),  56);
    check("p56_freq_ok", int'(freq_ok), 0);
    set_level(1'b1, 23);
    set_level(1'b0, 27);

    // Loss of clock: timeout exactly TMO cycles after the last rise.
    wave(27, 27, 3);
    set_level(1'b1, 27);
    set_level(1'b0, TMO - 27 + LAT - 1);
    check("tmo_before", int'(timeout), 0);
    set_level(1'b0, 1);
    check("tmo_set",     int'(timeout), 1);
    check("tmo_freq_ok", int'(freq_ok), 0);
    check("tmo_period",  int'(period),  54);
    set_level(1'b0, 10);
    // Recovery needs two edges.
    set_level(1'b1, 10);
    check("tmo_after_arm", int'(timeout), 1);
    set_level(1'b1, 17);
    set_level(1'b0, 27);
    set_level(1'b1, 4);
    check("tmo_recovered", int'(timeout), 0);
    check("tmo_rec_period", int'(period), 54);
    set_level(1'b1, 23);
    set_level(1'b0, 27);

    // Reset 20 cycles after a detected rise.
    set_level(1'b1, LAT + 20);
    do_reset();
    check("mid_rst_period",  int'(period),       0);
    check("mid_rst_high",    int'(high_time),    0);
    check("mid_rst_valid",   int'(period_valid), 0);
    check("mid_rst_freq_ok", int'(freq_ok),      0);
    check("mid_rst_timeout", int'(timeout),      0);
    set_level(1'b0, 13);
    wave(27, 27, 3);

    // Asymmetric 10/44.
    wave(10, 44, 4);
    set_level(1'b1, 4);
    check("asym_period",  int'(period),    54);
    check("asym_high",    int'(high_time), 10);
    check("asym_freq_ok", int'(freq_ok),   1);
    set_level(1'b1, 6);
    set_level(1'b0, 44);

    // Rise on the threshold cycle wins; one cycle later it is too late.
    wave(100, 100, 2);
    set_level(1'b1, 4);
    check("bound_period",  int'(period),  TMO);
    check("bound_timeout", int'(timeout), 0);
    set_level(1'b1, 96);
    set_level(1'b0, 101);
    set_level(1'b1, 4);
    check("over_timeout", int'(timeout), 1);
    check("over_period",  int'(period),  TMO);
    set_level(1'b1, 20);
    set_level(1'b0, 34);

    // Randomized periods, occasional long gaps and resets.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 19) == 0) do_reset();
      mode = int'($urandom_range(0, 3));
      if (mode == 0) begin
        h = int'($urandom_range(20, 30));
        l = EXP - h + int'($urandom_range(0, 2)) - 1;
      end else if (mode == 1) begin
        h = int'($urandom_range(1, 60));
        l = int'($urandom_range(150, 260));
      end else begin
        h = int'($urandom_range(1, 60));
        l = int'($urandom_range(1, 60));
      end
      set_level(1'b1, h);
      set_level(1'b0, l);
    end

    // Constant low from reset: timeout TMO cycles after reset.
    do_reset();
    set_level(1'b0, TMO - 1);
    check("idle_tmo_before", int'(timeout), 0);
    set_level(1'b0, 1);
    check("idle_tmo_set", int'(timeout), 1);
    set_level(1'b0, 20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
